// File: rtl/sram_target.sv
// Async-SRAM responder: an external master reads/writes a shared 2**AW x 16 RAM through
// synchronized CE/OE/WE/UB/LB strobes, while a local bus port reaches the same RAM.
module sram_target #(
    parameter int AW   = 12,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] ext_addr,
    input  logic [15:0]   ext_dq_in,
    output logic [15:0]   ext_dq_out,
    output logic          ext_dq_oe,
    input  logic          ext_ce_n,
    input  logic          ext_oe_n,
    input  logic          ext_we_n,
    input  logic          ext_ub_n,
    input  logic          ext_lb_n,
    input  logic [AW-1:0] addr,
    input  logic          r,
    input  logic [1:0]    w,
    input  logic [15:0]   dwrite,
    output logic [15:0]   data,
    output logic          ready,
    output logic          busy
);

    // Handshake: a local request (r or any w bit) is taken on the rising edge where
    // ready=1; while ready=0 the master keeps the request stable until it is taken.

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_ADDR   = 3'd1;
    localparam logic [2:0] RD_DRIVE  = 3'd2;
    localparam logic [2:0] WR_HOLD   = 3'd3;
    localparam logic [2:0] WR_COMMIT = 3'd4;

    logic [15:0]   mem [0:(1<<AW)-1];

    logic [4:0]    strb_sync [SYNC];   // {ce_n, oe_n, we_n, ub_n, lb_n}
    logic [AW-1:0] addr_sync [SYNC];
    logic [15:0]   dq_sync   [SYNC];

    logic          sce, soe, swe, sub, slb;
    logic [AW-1:0] saddr;
    logic [15:0]   sdq;

    logic [2:0]    state, nxt;
    logic [AW-1:0] cap_addr, rd_addr;
    logic [15:0]   cap_dq;
    logic [1:0]    cap_be;
    logic          reread;

    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    wr_be;
    logic [15:0]   ext_rd_word;

    assign {sce, soe, swe, sub, slb} = strb_sync[SYNC-1];
    assign saddr = addr_sync[SYNC-1];
    assign sdq   = dq_sync[SYNC-1];

    assign ready = (state != WR_COMMIT);
    assign busy  = (state != IDLE);

    // Combinational so a deasserted strobe or reset drops the pad within the cycle;
    // reread keeps the pad driven with stale data while an address change is refetched.
    assign ext_dq_oe = !sce && !soe && swe &&
                       ((state == RD_DRIVE) || ((state == RD_ADDR) && reread));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < SYNC; i++) begin
                strb_sync[i] <= '1;
                addr_sync[i] <= '0;
                dq_sync[i]   <= '0;
            end
        end else begin
            strb_sync[0] <= {ext_ce_n, ext_oe_n, ext_we_n, ext_ub_n, ext_lb_n};
            addr_sync[0] <= ext_addr;
            dq_sync[0]   <= ext_dq_in;
            for (int i = 1; i < SYNC; i++) begin
                strb_sync[i] <= strb_sync[i-1];
                addr_sync[i] <= addr_sync[i-1];
                dq_sync[i]   <= dq_sync[i-1];
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (!sce && !swe)      nxt = WR_HOLD;
                else if (!sce && !soe) nxt = RD_ADDR;
            end
            RD_ADDR:  nxt = RD_DRIVE;
            RD_DRIVE: begin
                if (sce || soe)             nxt = IDLE;
                else if (!swe)              nxt = WR_HOLD;
                else if (saddr != rd_addr)  nxt = RD_ADDR;
            end
            WR_HOLD:   if (swe || sce) nxt = WR_COMMIT;
            WR_COMMIT: nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Single RAM write port: an external commit stalls the local port for that cycle.
    always_comb begin
        if (state == WR_COMMIT) begin
            wr_addr = cap_addr;
            wr_data = cap_dq;
            wr_be   = cap_be;
        end else begin
            wr_addr = addr;
            wr_data = dwrite;
            wr_be   = w;
        end
    end

    // External read sees a same-cycle local write to the same word.
    always_comb begin
        ext_rd_word = mem[saddr];
        if (wr_addr == saddr) begin
            if (wr_be[0]) ext_rd_word[7:0]  = wr_data[7:0];
            if (wr_be[1]) ext_rd_word[15:8] = wr_data[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
        if (wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            cap_addr   <= '0;
            cap_dq     <= '0;
            cap_be     <= '0;
            rd_addr    <= '0;
            reread     <= 1'b0;
            ext_dq_out <= '0;
            data       <= '0;
        end else begin
            state  <= nxt;
            reread <= (state == RD_DRIVE) && (nxt == RD_ADDR);
            // Sampling stops once WE is seen high, so the last low-WE sample commits.
            if (nxt == WR_HOLD) begin
                cap_addr <= saddr;
                cap_dq   <= sdq;
                cap_be   <= {~sub, ~slb};
            end
            if (state == RD_ADDR) begin
                rd_addr    <= saddr;
                ext_dq_out <= ext_rd_word;
            end
            if (r && ready) data <= mem[addr];
        end
    end

endmodule
